button_counter: RTL and testbench
=================================

BUTTON_COUNTER -- requirements
Module: button_counter

Interface
REQ-001 Parameter: DB_CYCLES, default 16, debounce qualification length in clk cycles (legal range 2..2^20).
REQ-002 Parameter: WIDTH, default 16, count width in bits; four hex digits at default.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: btn_inc  input  1  raw asynchronous increment button, active-high.
REQ-006 Port: btn_dec  input  1  raw asynchronous decrement button, active-high.
REQ-007 Port: count  output  WIDTH  registered event count, consumed nibble-wise by the hex display stage.
REQ-008 Port: inc_pulse  output  1  registered one-cycle strobe per accepted increment press.
REQ-009 Port: dec_pulse  output  1  registered one-cycle strobe per accepted decrement press.
REQ-010 Port: wrap  output  1  registered one-cycle strobe when count wraps in either direction.

Function
REQ-011 Each button SHALL pass through its own 2-flop synchronizer (s1, s2) before any other logic.
REQ-012 Each button SHALL have a debouncer: a stable-state register plus a qualification counter of ceil(log2(DB_CYCLES)) bits.
REQ-013 Debouncer: s2 == stable -> counter cleared to 0.
REQ-014 Debouncer: s2 != stable and counter < DB_CYCLES-1 -> counter increments.
REQ-015 Debouncer: s2 != stable and counter == DB_CYCLES-1 -> stable <= s2 and counter <= 0 on the same edge.
REQ-016 Net effect: a level change SHALL be accepted only after DB_CYCLES consecutive s2 samples differ from stable; any shorter excursion SHALL be discarded without effect.
REQ-017 Pulse rule: inc_pulse/dec_pulse SHALL be set on the edge where stable changes 0->1, high for exactly one cycle; a 1->0 change SHALL produce no pulse.
REQ-018 Latency: btn first sampled high at edge k and held -> pulse high in the cycle after edge k+DB_CYCLES+1; count updated at edge k+DB_CYCLES+2.
REQ-019 Count update from registered pulses: inc only -> count+1 mod 2^WIDTH; dec only -> count-1 mod 2^WIDTH.
REQ-020 Simultaneous inc_pulse and dec_pulse -> count unchanged, wrap not asserted.
REQ-021 wrap SHALL assert on the same edge count changes all-ones->0 (increment) or 0->all-ones (decrement), for exactly one cycle.
REQ-022 A held button SHALL produce exactly one pulse per press, regardless of hold duration.
REQ-023 Button bounce (alternating s2 values) SHALL restart qualification and yield at most one pulse once the level settles.

Reset
REQ-024 While reset is high at a clk edge: s1, s2, stable registers, qualification counters, count, inc_pulse, dec_pulse and wrap SHALL all load 0.
REQ-025 reset SHALL override all other activity on that edge, including a pulse or count update due on the same edge.
REQ-026 Reset asserted mid-qualification SHALL discard the partial qualification.
REQ-027 A button still held when reset deasserts SHALL be qualified afresh from stable=0 and produce one pulse per REQ-018, with k = first edge after deassertion.

Verification (DB_CYCLES=4, WIDTH=16)
REQ-028 Reset, then btn_inc high held 20 cycles from edge 0 -> inc_pulse high only in cycle after edge 5; count=0x0001 after edge 6; no further pulse.
REQ-029 btn_inc high for 3 cycles, then low -> no inc_pulse; count stays 0x0000.
REQ-030 From count=0, one dec press -> dec_pulse and wrap high together for one cycle, count=0xFFFF; then one inc press -> wrap pulse, count=0x0000.
REQ-031 btn_inc and btn_dec rise on the same edge and are held -> both pulses in the same cycle; count unchanged; wrap low.
REQ-032 btn_inc held; reset for one cycle when qualification counter=2; button still held -> all outputs 0; inc_pulse appears after edge r+5, where r is the first edge with reset low.
REQ-033 btn_inc sampled 1,0,1,0,1 then held high -> exactly one inc_pulse, 5 edges after the final 0->1 sample; count=0x0001.

Source files
------------

// File: rtl/button_counter.sv
// Two-button up/down event counter.
// Each raw button is synchronised into clk, debounced by a qualification
// counter, and turned into a one-cycle press strobe on an accepted rising
// level. The strobes then step a WIDTH-bit wrapping count; wrap flags the
// all-ones <-> zero transition in either direction.
module button_counter #(
    parameter int DB_CYCLES = 16,
    parameter int WIDTH     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_inc,
    input  logic             btn_dec,
    output logic [WIDTH-1:0] count,
    output logic             inc_pulse,
    output logic             dec_pulse,
    output logic             wrap
);

    // Qualification counter width; at least one bit even for DB_CYCLES = 2.
    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] QUAL_MAX = CW'(DB_CYCLES - 1);

    // Index 0 is the increment button, index 1 the decrement button.
    logic [1:0] btn_raw;
    logic [1:0] press_pulse;

    assign btn_raw = {btn_dec, btn_inc};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic          s1_reg;
            logic          s2_reg;
            logic          stable_reg;
            logic          pulse_reg;
            logic [CW-1:0] qual_cnt_reg;

            // Two-flop synchroniser for the asynchronous button input.
            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= btn_raw[gi];
                    s2_reg <= s1_reg;
                end
            end

            // Debouncer: a new level is accepted only after DB_CYCLES
            // consecutive differing samples; any agreeing sample restarts it.
            // The press strobe fires on the edge the accepted level goes high.
            always_ff @(posedge clk) begin
                if (reset) begin
                    stable_reg   <= 1'b0;
                    qual_cnt_reg <= '0;
                    pulse_reg    <= 1'b0;
                end else begin
                    pulse_reg <= 1'b0;
                    if (s2_reg == stable_reg) begin
                        qual_cnt_reg <= '0;
                    end else if (qual_cnt_reg == QUAL_MAX) begin
                        stable_reg   <= s2_reg;
                        qual_cnt_reg <= '0;
                        pulse_reg    <= s2_reg;
                    end else begin
                        qual_cnt_reg <= qual_cnt_reg + CW'(1);
                    end
                end
            end

            assign press_pulse[gi] = pulse_reg;
        end
    endgenerate

    assign inc_pulse = press_pulse[0];
    assign dec_pulse = press_pulse[1];

    logic [WIDTH-1:0] count_reg;
    logic             wrap_reg;

    // Count update from the registered strobes; simultaneous presses cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            wrap_reg <= 1'b0;
            case (press_pulse)
                2'b01: begin
                    count_reg <= count_reg + WIDTH'(1);
                    wrap_reg  <= &count_reg;
                end
                2'b10: begin
                    count_reg <= count_reg - WIDTH'(1);
                    wrap_reg  <= ~|count_reg;
                end
                default: ;
            endcase
        end
    end

    assign count = count_reg;
    assign wrap  = wrap_reg;

endmodule

// File: tb/tb_button_counter.sv
// Bench for button_counter at DB_CYCLES=4, WIDTH=16: directed scenarios
// followed by randomized button activity, all checked against a
// history-based reference model.
module tb_button_counter;

    localparam int DB   = 4;
    localparam int W    = 16;
    localparam int LOGN = 8192;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          btn_inc = 1'b0;
    logic          btn_dec = 1'b0;
    logic [W-1:0]  count;
    logic          inc_pulse;
    logic          dec_pulse;
    logic          wrap;

    button_counter #(.DB_CYCLES(DB), .WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .count     (count),
        .inc_pulse (inc_pulse),
        .dec_pulse (dec_pulse),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a log of raw samples per edge. The synchronised view
    // of a button at edge n is the raw value two edges earlier (zero if that
    // predates the last reset). A level flips once the last DB synchronised
    // samples, all taken after the last reset and the last flip, disagree
    // with the accepted level.
    bit [1:0] raw_log [LOGN];
    bit [1:0] s2_log  [LOGN];
    int       ed = 0;
    int       last_rst = 0;
    int       last_flip [2];
    bit [1:0] m_stable = 2'b00;
    bit [1:0] m_pulse = 2'b00;
    int       m_count = 0;
    bit       m_wrap = 1'b0;

    task automatic model_edge();
        bit inc_o;
        bit dec_o;
        bit s2v;
        bit ok;
        int floor_e;
        raw_log[ed] = {btn_dec, btn_inc};
        if (reset) begin
            last_rst     = ed;
            last_flip[0] = ed;
            last_flip[1] = ed;
            m_stable     = 2'b00;
            m_pulse      = 2'b00;
            m_count      = 0;
            m_wrap       = 1'b0;
            s2_log[ed]   = 2'b00;
        end else begin
            inc_o  = m_pulse[0];
            dec_o  = m_pulse[1];
            m_wrap = 1'b0;
            if (inc_o && !dec_o) begin
                m_wrap  = (m_count == 65535);
                m_count = (m_count + 1) % 65536;
            end else if (dec_o && !inc_o) begin
                m_wrap  = (m_count == 0);
                m_count = (m_count + 65535) % 65536;
            end
            for (int b = 0; b < 2; b++) begin
                s2v = (ed - 2 > last_rst) ? raw_log[ed-2][b] : 1'b0;
                s2_log[ed][b] = s2v;
                floor_e = (last_rst > last_flip[b]) ? last_rst : last_flip[b];
                ok = (ed - DB + 1 > floor_e);
                if (ok) begin
                    for (int j = 0; j < DB; j++) begin
                        if (s2_log[ed-j][b] == m_stable[b]) ok = 1'b0;
                    end
                end
                if (ok) begin
                    m_stable[b]  = ~m_stable[b];
                    last_flip[b] = ed;
                    m_pulse[b]   = m_stable[b];
                end else begin
                    m_pulse[b] = 1'b0;
                end
            end
        end
        ed++;
    endtask

    // Per-scenario observations of the DUT.
    int inc_seen, dec_seen, wrap_seen, first_inc, first_dec, sidx;

    task automatic clear_stats();
        inc_seen  = 0;
        dec_seen  = 0;
        wrap_seen = 0;
        first_inc = -1;
        first_dec = -1;
        sidx      = 0;
    endtask

    // One clock: drive inputs, advance model at the edge, compare at negedge.
    task automatic step(input bit r, input bit i, input bit d);
        reset   = r;
        btn_inc = i;
        btn_dec = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("count", 32'(count), 32'(m_count));
        check("inc_pulse", 32'(inc_pulse), 32'(m_pulse[0]));
        check("dec_pulse", 32'(dec_pulse), 32'(m_pulse[1]));
        check("wrap", 32'(wrap), 32'(m_wrap));
        if (inc_pulse) begin
            inc_seen++;
            if (first_inc < 0) first_inc = sidx;
        end
        if (dec_pulse) begin
            dec_seen++;
            if (first_dec < 0) first_dec = sidx;
        end
        if (wrap) wrap_seen++;
        sidx++;
    endtask

    task automatic run(input int n, input bit i, input bit d);
        for (int k = 0; k < n; k++) step(1'b0, i, d);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        clear_stats();
    endtask

    int hold_i, hold_d;
    bit ri, rd, rr;

    initial begin
        last_flip[0] = 0;
        last_flip[1] = 0;
        clear_stats();

        // Reset state.
        do_reset();
        check("rst_count", 32'(count), 32'h0);
        check("rst_outs", {29'd0, inc_pulse, dec_pulse, wrap}, 32'h0);

        // Held press: one pulse after edge 5, count 1, no repeat.
        run(20, 1'b1, 1'b0);
        check("held_pulses", inc_seen, 1);
        check("held_latency", first_inc, 5);
        check("held_count", 32'(count), 32'h1);
        $display("held press: pulses=%0d first=%0d count=%0h", inc_seen, first_inc, count);

        // Short glitch of 3 cycles is discarded.
        do_reset();
        run(3, 1'b1, 1'b0);
        run(10, 1'b0, 1'b0);
        check("short_pulses", inc_seen, 0);
        check("short_count", 32'(count), 32'h0);
        $display("short glitch: pulses=%0d count=%0h", inc_seen, count);

        // Decrement wrap from zero, then increment wrap back.
        do_reset();
        run(8, 1'b0, 1'b1);
        run(8, 1'b0, 1'b0);
        check("dec_wrap_count", 32'(count), 32'hFFFF);
        check("dec_wrap_seen", wrap_seen, 1);
        check("dec_pulses", dec_seen, 1);
        run(8, 1'b1, 1'b0);
        run(8, 1'b0, 1'b0);
        check("inc_wrap_count", 32'(count), 32'h0);
        check("inc_wrap_seen", wrap_seen, 2);
        $display("wrap: count=%0h wraps=%0d", count, wrap_seen);

        // Simultaneous presses cancel.
        do_reset();
        run(10, 1'b1, 1'b1);
        check("both_inc", inc_seen, 1);
        check("both_dec", dec_seen, 1);
        check("both_same_cycle", first_inc, first_dec);
        check("both_count", 32'(count), 32'h0);
        check("both_wrap", wrap_seen, 0);
        $display("simultaneous: inc=%0d dec=%0d count=%0h", inc_seen, dec_seen, count);

        // Reset mid-qualification with the button still held.
        do_reset();
        run(4, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("midrst_outs", {count, inc_pulse, dec_pulse, wrap}, 32'h0);
        clear_stats();
        run(15, 1'b1, 1'b0);
        check("midrst_latency", first_inc, 5);
        check("midrst_pulses", inc_seen, 1);
        check("midrst_count", 32'(count), 32'h1);
        $display("mid reset: first=%0d count=%0h", first_inc, count);

        // Bounce 1,0,1,0,1 then held.
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        run(16, 1'b1, 1'b0);
        check("bounce_pulses", inc_seen, 1);
        check("bounce_latency", first_inc, 9);
        check("bounce_count", 32'(count), 32'h1);
        $display("bounce: pulses=%0d first=%0d count=%0h", inc_seen, first_inc, count);

        // Randomized activity with occasional resets.
        do_reset();
        hold_i = 0;
        hold_d = 0;
        ri = 1'b0;
        rd = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (hold_i == 0) begin
                ri = 1'($urandom_range(0, 1));
                hold_i = $urandom_range(1, 10);
            end
            if (hold_d == 0) begin
                rd = 1'($urandom_range(0, 1));
                hold_d = $urandom_range(1, 10);
            end
            hold_i--;
            hold_d--;
            rr = ($urandom_range(0, 299) == 0);
            step(rr, ri, rd);
        end
        $display("random: inc=%0d dec=%0d wraps=%0d final count=%0h", inc_seen, dec_seen, wrap_seen, count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
